// File: rtl/bosconian_video_pkg.sv
// Shared timing defaults and types for the Bosconian raster sequencer.
package bosconian_video_pkg;

   localparam int unsigned CE_DIV_DEF       = 8;
   localparam int unsigned H_TOTAL_DEF      = 384;
   localparam int unsigned H_ACTIVE_DEF     = 288;
   localparam int unsigned H_SYNC_START_DEF = 312;
   localparam int unsigned H_SYNC_LEN_DEF   = 32;
   localparam int unsigned V_TOTAL_NTSC_DEF = 264;
   localparam int unsigned V_TOTAL_PAL_DEF  = 312;
   localparam int unsigned V_ACTIVE_DEF     = 224;
   localparam int unsigned V_SYNC_START_DEF = 240;
   localparam int unsigned V_SYNC_LEN_DEF   = 3;

   // PAL frames are longer, so VSync moves down by this many lines.
   localparam int unsigned PAL_VS_OFS = 24;

   typedef logic [8:0] cnt_t;

endpackage

// File: rtl/bosconian_ce_div.sv
// Clock divider producing a one-clock enable strobe every DIV clocks.
// tick is the combinational wrap condition; ce is the registered strobe
// that goes high on the same edge the wrap takes effect.
module bosconian_ce_div #(
   parameter int unsigned DIV = 8
) (
   input  logic clk,
   input  logic rst,
   output logic tick,
   output logic ce
);

   localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;

   assign tick = (cnt == W'(DIV - 1));

   // Free-running divider; ce registers the wrap so it lasts one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         ce  <= 1'b0;
      end else begin
         ce  <= tick;
         cnt <= tick ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/bosconian_video_timing.sv
// Raster sequencer for the Bosconian core: pixel enable, h/v counters,
// blanking/sync decode with NTSC/PAL line counts and per-frame sync offsets.
// Optional feature: define BOSCONIAN_VBLANK_IRQ_EN to add irq_ack/vblank_irq.
module bosconian_video_timing
   import bosconian_video_pkg::*;
#(
   parameter int unsigned CE_DIV       = CE_DIV_DEF,
   parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
   parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
   parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
   parameter int unsigned H_SYNC_LEN   = H_SYNC_LEN_DEF,
   parameter int unsigned V_TOTAL_NTSC = V_TOTAL_NTSC_DEF,
   parameter int unsigned V_TOTAL_PAL  = V_TOTAL_PAL_DEF,
   parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
   parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
   parameter int unsigned V_SYNC_LEN   = V_SYNC_LEN_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pal,
   input  logic [3:0] h_ofs,
   input  logic [3:0] v_ofs,
   output logic       ce_pix,
   output logic [8:0] hcnt,
   output logic [8:0] vcnt,
   output logic       HBlank,
   output logic       VBlank,
   output logic       HSync,
   output logic       VSync,
   output logic       line_start,
   output logic       frame_start
`ifdef BOSCONIAN_VBLANK_IRQ_EN
   ,
   input  logic       irq_ack,
   output logic       vblank_irq
`endif
);

   logic        tick;
   logic        running;
   logic        pal_l;
   logic [3:0]  h_ofs_l;
   logic [3:0]  v_ofs_l;

   cnt_t        h_nx;
   cnt_t        v_nx;
   cnt_t        vtot;
   logic        frame_wrap;
   logic        pal_nx;
   logic [3:0]  h_ofs_nx;
   logic [3:0]  v_ofs_nx;

   logic signed [9:0] h10, v10;
   logic signed [9:0] hs, hs_end, vs, vs_end;
   logic        hblank_nx, vblank_nx, hsync_nx, vsync_nx;

   bosconian_ce_div #(
      .DIV (CE_DIV)
   ) u_ce_div (
      .clk  (clk),
      .rst  (reset),
      .tick (tick),
      .ce   (ce_pix)
   );

   // Next raster position and the config that applies to it. The first
   // strobe after reset lands on (0,0) rather than advancing, so it
   // counts as a frame boundary and latches the config.
   always_comb begin
      h_nx       = hcnt;
      v_nx       = vcnt;
      frame_wrap = 1'b0;
      vtot       = pal_l ? 9'(V_TOTAL_PAL) : 9'(V_TOTAL_NTSC);
      if (!running) begin
         h_nx       = '0;
         v_nx       = '0;
         frame_wrap = 1'b1;
      end else if (hcnt == 9'(H_TOTAL - 1)) begin
         h_nx = '0;
         if (vcnt == vtot - 9'd1) begin
            v_nx       = '0;
            frame_wrap = 1'b1;
         end else begin
            v_nx = vcnt + 9'd1;
         end
      end else begin
         h_nx = hcnt + 9'd1;
      end
      pal_nx   = frame_wrap ? pal   : pal_l;
      h_ofs_nx = frame_wrap ? h_ofs : h_ofs_l;
      v_ofs_nx = frame_wrap ? v_ofs : v_ofs_l;
   end

   // Blank/sync decode of the next position; sync windows are signed and
   // simply miss any line/pixel beyond the total instead of wrapping.
   always_comb begin
      h10       = {1'b0, h_nx};
      v10       = {1'b0, v_nx};
      hs        = 10'(H_SYNC_START) + {{6{h_ofs_nx[3]}}, h_ofs_nx};
      hs_end    = hs + 10'(H_SYNC_LEN);
      vs        = (pal_nx ? 10'(V_SYNC_START + PAL_VS_OFS) : 10'(V_SYNC_START))
                  + {{6{v_ofs_nx[3]}}, v_ofs_nx};
      vs_end    = vs + 10'(V_SYNC_LEN);
      hblank_nx = (h_nx >= 9'(H_ACTIVE));
      vblank_nx = (v_nx >= 9'(V_ACTIVE));
      hsync_nx  = (h10 >= hs) && (h10 < hs_end);
      vsync_nx  = (v10 >= vs) && (v10 < vs_end);
   end

   // Counters, latched config and decoded outputs, all updated on the pixel edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         running     <= 1'b0;
         hcnt        <= '0;
         vcnt        <= '0;
         pal_l       <= 1'b0;
         h_ofs_l     <= '0;
         v_ofs_l     <= '0;
         HBlank      <= 1'b0;
         VBlank      <= 1'b0;
         HSync       <= 1'b0;
         VSync       <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (tick) begin
            running     <= 1'b1;
            hcnt        <= h_nx;
            vcnt        <= v_nx;
            pal_l       <= pal_nx;
            h_ofs_l     <= h_ofs_nx;
            v_ofs_l     <= v_ofs_nx;
            HBlank      <= hblank_nx;
            VBlank      <= vblank_nx;
            HSync       <= hsync_nx;
            VSync       <= vsync_nx;
            line_start  <= (h_nx == '0);
            frame_start <= (h_nx == '0) && (v_nx == '0);
         end
      end
   end

`ifdef BOSCONIAN_VBLANK_IRQ_EN
   // Sticky VBlank interrupt; a set on the rising edge beats a same-clock ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vblank_irq <= 1'b0;
      end else if (tick && vblank_nx && !VBlank) begin
         vblank_irq <= 1'b1;
      end else if (irq_ack) begin
         vblank_irq <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_bosconian_video_timing.sv
// Directed bench for bosconian_video_timing using a scaled-down raster
// (24 pixels x 12/40 lines, CE_DIV 8) so whole frames fit in a short run.
module tb_bosconian_video_timing;

   localparam int unsigned CE  = 8;
   localparam int unsigned HT  = 24;
   localparam int unsigned HA  = 12;
   localparam int unsigned HSS = 16;
   localparam int unsigned HSL = 4;
   localparam int unsigned VTN = 12;
   localparam int unsigned VTP = 40;
   localparam int unsigned VA  = 6;
   localparam int unsigned VSS = 8;
   localparam int unsigned VSL = 3;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       pal   = 1'b0;
   logic [3:0] h_ofs = 4'd0;
   logic [3:0] v_ofs = 4'd0;
   logic       ce_pix;
   logic [8:0] hcnt;
   logic [8:0] vcnt;
   logic       HBlank, VBlank, HSync, VSync;
   logic       line_start, frame_start;
`ifdef BOSCONIAN_VBLANK_IRQ_EN
   logic       irq_ack = 1'b0;
   logic       vblank_irq;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int cyc_rel  = 0;

   bosconian_video_timing #(
      .CE_DIV       (CE),
      .H_TOTAL      (HT),
      .H_ACTIVE     (HA),
      .H_SYNC_START (HSS),
      .H_SYNC_LEN   (HSL),
      .V_TOTAL_NTSC (VTN),
      .V_TOTAL_PAL  (VTP),
      .V_ACTIVE     (VA),
      .V_SYNC_START (VSS),
      .V_SYNC_LEN   (VSL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pal         (pal),
      .h_ofs       (h_ofs),
      .v_ofs       (v_ofs),
      .ce_pix      (ce_pix),
      .hcnt        (hcnt),
      .vcnt        (vcnt),
      .HBlank      (HBlank),
      .VBlank      (VBlank),
      .HSync       (HSync),
      .VSync       (VSync),
      .line_start  (line_start),
      .frame_start (frame_start)
`ifdef BOSCONIAN_VBLANK_IRQ_EN
      ,
      .irq_ack     (irq_ack),
      .vblank_irq  (vblank_irq)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance to the next negedge at which ce_pix is high (bounded).
   task automatic next_ce();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ce_pix && n < 64);
      chk("ce_timeout", 32'(ce_pix), 32'd1);
   endtask

   task automatic goto_pos(input int v, input int h);
      int n;
      n = 0;
      do begin
         next_ce();
         n++;
      end while (!(int'(vcnt) == v && int'(hcnt) == h) && n < 1200);
      chk("goto_reached", 32'(int'(vcnt) == v && int'(hcnt) == h), 32'd1);
   endtask

   // Release reset and check the first strobes.
   task automatic release_and_check(input string tag);
      int t;
      @(negedge clk);
      reset   = 1'b0;
      cyc_rel = cyc;
      next_ce();
      chk({tag, "_first_ce_clk"}, 32'(cyc - cyc_rel), 32'd8);
      chk({tag, "_first_hcnt"}, 32'(hcnt), 32'd0);
      chk({tag, "_first_vcnt"}, 32'(vcnt), 32'd0);
      chk({tag, "_first_flags"}, 32'({HBlank, VBlank, HSync, VSync}), 32'd0);
      chk({tag, "_first_strobes"}, 32'({line_start, frame_start}), 32'd3);
      t = cyc;
      next_ce();
      chk({tag, "_ce_period"}, 32'(cyc - t), 32'd8);
      chk({tag, "_second_hcnt"}, 32'(hcnt), 32'd1);
      chk({tag, "_second_strobes"}, 32'({line_start, frame_start}), 32'd0);
   endtask

   // Walk one frame starting at a frame_start sample, collect extents and
   // compare them to the expected values. Optionally changes pal/h_ofs
   // when (chg_v, 0) is reached.
   task automatic scan_frame(input string tag, input int exp_period, input int exp_lines,
                             input int exp_hsf, input int exp_hsl,
                             input int exp_vsf, input int exp_vsl,
                             input int chg_v, input logic npal, input logic [3:0] nh);
      int t0, n, nlines, max_v;
      int hbf, hbl, hsf, hsl, vbf, vsf, vsl;
      t0 = cyc; n = 0; nlines = 0; max_v = -1;
      hbf = 999; hbl = -1; hsf = 999; hsl = -1; vbf = 999; vsf = 999; vsl = -1;
      chk({tag, "_starts_on_frame"}, 32'(frame_start), 32'd1);
      do begin
         if (int'(vcnt) == chg_v && hcnt == 9'd0) begin
            pal   = npal;
            h_ofs = nh;
         end
         if (line_start) nlines++;
         if (int'(vcnt) > max_v) max_v = int'(vcnt);
         if (HBlank) begin
            if (int'(hcnt) < hbf) hbf = int'(hcnt);
            if (int'(hcnt) > hbl) hbl = int'(hcnt);
         end
         if (HSync) begin
            if (int'(hcnt) < hsf) hsf = int'(hcnt);
            if (int'(hcnt) > hsl) hsl = int'(hcnt);
         end
         if (VBlank && int'(vcnt) < vbf) vbf = int'(vcnt);
         if (VSync) begin
            if (int'(vcnt) < vsf) vsf = int'(vcnt);
            if (int'(vcnt) > vsl) vsl = int'(vcnt);
         end
         next_ce();
         n++;
      end while (!frame_start && n < 1200);
      chk({tag, "_frame_end"}, 32'(frame_start), 32'd1);
      chk({tag, "_period"}, 32'(cyc - t0), 32'(exp_period));
      chk({tag, "_lines"}, 32'(nlines), 32'(exp_lines));
      chk({tag, "_max_v"}, 32'(max_v), 32'(exp_lines - 1));
      chk({tag, "_hblank_first"}, 32'(hbf), 32'd12);
      chk({tag, "_hblank_last"}, 32'(hbl), 32'd23);
      chk({tag, "_vblank_first"}, 32'(vbf), 32'd6);
      chk({tag, "_hsync_first"}, 32'(hsf), 32'(exp_hsf));
      chk({tag, "_hsync_last"}, 32'(hsl), 32'(exp_hsl));
      chk({tag, "_vsync_first"}, 32'(vsf), 32'(exp_vsf));
      chk({tag, "_vsync_last"}, 32'(vsl), 32'(exp_vsl));
   endtask

   initial begin
      // Reset state while held.
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({ce_pix, hcnt, vcnt, HBlank, VBlank, HSync, VSync,
                                line_start, frame_start}), 32'd0);

      release_and_check("rel1");
      goto_pos(0, 0);

      // NTSC frame at default offsets.
      scan_frame("ntsc_a", 2304, 12, 16, 19, 8, 10, -1, 1'b0, 4'd0);
      // pal raised just after the latch edge: this frame stays NTSC.
      pal = 1'b1;
      scan_frame("ntsc_b", 2304, 12, 16, 19, 8, 10, -1, 1'b0, 4'd0);
      scan_frame("pal_c", 7680, 40, 16, 19, 32, 34, -1, 1'b0, 4'd0);
      // Mid-frame switch to NTSC with h_ofs=-8: current PAL frame unchanged.
      scan_frame("pal_d", 7680, 40, 16, 19, 32, 34, 4, 1'b0, 4'b1000);
      h_ofs = 4'd7;
      v_ofs = 4'd7;
      scan_frame("ntsc_e", 2304, 12, 8, 11, 8, 10, -1, 1'b0, 4'd7);
      h_ofs = 4'b1000;
      v_ofs = 4'b1000;
      // +7 offsets: HSync clipped to the last pixel, VSync pushed past the frame.
      scan_frame("clip_f", 2304, 12, 23, 23, 999, -1, -1, 1'b0, 4'b1000);
      pal   = 1'b0;
      h_ofs = 4'd0;
      v_ofs = 4'd0;
      // -8 offsets: VSync moves to the top lines.
      scan_frame("neg_g", 2304, 12, 8, 11, 0, 2, -1, 1'b0, 4'd0);

      // Asynchronous reset in the middle of a line.
      goto_pos(3, 10);
      chk("pre_reset_hcnt", 32'(hcnt), 32'd10);
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_outputs", 32'({ce_pix, hcnt, vcnt, HBlank, VBlank, HSync, VSync,
                                      line_start, frame_start}), 32'd0);
      release_and_check("rel2");
      goto_pos(0, 0);
      scan_frame("restart", 2304, 12, 16, 19, 8, 10, -1, 1'b0, 4'd0);

`ifdef BOSCONIAN_VBLANK_IRQ_EN
      chk("irq_held_after_vblank", 32'(vblank_irq), 32'd1);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      chk("irq_cleared_by_ack", 32'(vblank_irq), 32'd0);
      goto_pos(5, 23);
      chk("irq_low_before_vblank", 32'(vblank_irq), 32'd0);
      irq_ack = 1'b1;
      next_ce();
      chk("irq_rise_vcnt", 32'(vcnt), 32'd6);
      chk("irq_set_beats_ack", 32'(vblank_irq), 32'd1);
      irq_ack = 1'b0;
      next_ce();
      next_ce();
      chk("irq_sticky", 32'(vblank_irq), 32'd1);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      chk("irq_ack_clears", 32'(vblank_irq), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
